// File: rtl/h_read_burst_ctrl_if.sv
// Bus bundle for the read-burst sequencer: AXI AR/R channels on one side,
// AHB-Lite read master signals on the other.
interface h_read_burst_ctrl_if;
  // AXI AR channel
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic [2:0]  ar_size;
  logic [3:0]  ar_id;
  // AXI R channel
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [3:0]  r_id;
  logic [1:0]  r_resp;
  logic        r_last;
  // AHB-Lite master side
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;

  // Bridge view: serves AXI reads, drives the AHB bus
  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, ar_id,
    output ar_ready,
    output r_valid, r_data, r_id, r_resp, r_last,
    input  r_ready,
    output haddr, htrans, hsize, hburst, hwrite,
    input  hready, hrdata, hresp
  );

  // Environment view: issues AXI reads, models the AHB slave
  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_id, r_resp, r_last,
    output r_ready,
    input  haddr, htrans, hsize, hburst, hwrite,
    output hready, hrdata, hresp
  );
endinterface

// File: rtl/h_read_burst_ctrl.sv
// Read-path sequencer: one AXI INCR read burst becomes a series of
// non-overlapping AHB SINGLE reads, each beat drained on R before the next
// address phase. Illegal sizes are answered with SLVERR beats, no AHB access.
module h_read_burst_ctrl (
  input  logic                   clk,
  input  logic                   resetn,
  h_read_burst_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_RESP = 3'd3,
    S_ERRB = 3'd4
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;

  logic last_beat;
  logic r_valid;

  assign last_beat = (beat_cnt_q == len_q);
  assign r_valid   = (state_q == S_RESP) || (state_q == S_ERRB);

  // State and burst context registers; async reset drops any burst in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      id_q       <= '0;
      beat_cnt_q <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      size_q     <= size_d;
      id_q       <= id_d;
      beat_cnt_q <= beat_cnt_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // Next-state and register updates for the per-beat address/data/response cycle
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    size_d     = size_q;
    id_d       = id_q;
    beat_cnt_d = beat_cnt_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ar_valid) begin
          base_d     = bus.ar_addr;
          len_d      = bus.ar_len;
          size_d     = bus.ar_size;
          id_d       = bus.ar_id;
          beat_cnt_d = '0;
          if (bus.ar_size > 3'd2) begin
            // Error beats carry fixed payload; load it once on entry
            r_data_d = '0;
            r_resp_d = RESP_SLVERR;
            state_d  = S_ERRB;
          end else begin
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.hready) state_d = S_DATA;
      end
      S_DATA: begin
        // First error cycle has hready low and simply waits here
        if (bus.hready) begin
          r_data_d = bus.hresp ? 32'd0 : bus.hrdata;
          r_resp_d = bus.hresp ? RESP_SLVERR : RESP_OKAY;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.r_ready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            state_d    = S_ADDR;
          end
        end
      end
      S_ERRB: begin
        if (bus.r_ready) begin
          if (last_beat) state_d = S_IDLE;
          else           beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset takes effect at once
  assign bus.ar_ready = (state_q == S_IDLE);
  assign bus.htrans   = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  // Address wraps mod 2^32; no 1 KB / 4 KB boundary splitting
  assign bus.haddr    = base_q + ({28'd0, beat_cnt_q} << size_q);
  assign bus.hsize    = size_q;
  assign bus.hburst   = 3'b000;
  assign bus.hwrite   = 1'b0;
  assign bus.r_valid  = r_valid;
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.r_id     = id_q;
  assign bus.r_last   = r_valid && last_beat;

endmodule
